// File: rtl/imem_loader.sv
// ============================================================================
//  Module      : imem_loader
//  Description : Streams program bytes into 32-bit little-endian words and
//                writes them into instruction memory, holding the CPU while
//                a load is in progress.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader #(
   parameter int DEPTH = 64
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [6:0]  word_count,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   output logic        we,
   output logic [7:0]  waddr,
   output logic [31:0] wdata,
   output logic        cpu_hold,
   output logic        done
);

   localparam logic [6:0] DEPTH_CNT = 7'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_WRITE   = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [6:0]  count;
   logic [6:0]  word_idx;
   logic [1:0]  byte_idx;
   logic [23:0] word_buf;
   logic [6:0]  start_count;
   logic        accept;
   logic        last_word;

   // Requested length saturated at the memory depth
   assign start_count = (word_count > DEPTH_CNT) ? DEPTH_CNT : word_count;
   assign accept      = byte_valid && (state == S_COLLECT);
   assign last_word   = (word_idx == (count - 7'd1));

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and Moore outputs; all outputs decode from the state so reset
   // forces them low without waiting for a clock edge
   always_comb begin
      state_next = state;
      byte_ready = 1'b0;
      we         = 1'b0;
      done       = 1'b0;
      cpu_hold   = 1'b1;
      case (state)
         S_IDLE: begin
            cpu_hold = 1'b0;
            if (start) begin
               state_next = (start_count == 7'd0) ? S_DONE : S_COLLECT;
            end
         end
         S_COLLECT: begin
            byte_ready = 1'b1;
            if (byte_valid && (byte_idx == 2'd3)) begin
               state_next = S_WRITE;
            end
         end
         S_WRITE: begin
            we         = 1'b1;
            state_next = last_word ? S_DONE : S_COLLECT;
         end
         S_DONE: begin
            done       = 1'b1;
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Datapath: length latch, byte assembly, write address/data registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count    <= 7'd0;
         word_idx <= 7'd0;
         byte_idx <= 2'd0;
         word_buf <= 24'd0;
         waddr    <= 8'd0;
         wdata    <= 32'd0;
      end else begin
         if ((state == S_IDLE) && start) begin
            count    <= start_count;
            word_idx <= 7'd0;
            byte_idx <= 2'd0;
         end
         if (accept) begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
               2'd0: word_buf[7:0]   <= byte_data;
               2'd1: word_buf[15:8]  <= byte_data;
               2'd2: word_buf[23:16] <= byte_data;
               default: begin
                  // Final byte completes the word; present it during WRITE
                  wdata <= {byte_data, word_buf};
                  waddr <= {word_idx[5:0], 2'b00};
               end
            endcase
         end
         if ((state == S_WRITE) && !last_word) begin
            word_idx <= word_idx + 7'd1;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Randomized scoreboard bench for imem_loader.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

   typedef struct {
      logic [7:0]  addr;
      logic [31:0] data;
   } wr_t;

   logic        clk;
   logic        reset;
   logic        start;
   logic [6:0]  word_count;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        we;
   logic [7:0]  waddr;
   logic [31:0] wdata;
   logic        cpu_hold;
   logic        done;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          done_cnt = 0;
   int          done_cyc = 0;
   int          exp_done = 0;

   wr_t         exp_q[$];
   int          we_cyc_q[$];
   logic [7:0]  byte_q[$];
   int          gb_q[$];
   logic [31:0] words[$];

   imem_loader #(.DEPTH(64)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .word_count (word_count),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .we         (we),
      .waddr      (waddr),
      .wdata      (wdata),
      .cpu_hold   (cpu_hold),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Free-running cycle index used to time-stamp observed events
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops the scoreboard on every write pulse and every done pulse
   always @(negedge clk) begin
      if (we) begin
         we_cyc_q.push_back(cyc);
         if (exp_q.size() == 0) begin
            check("unexpected_we", 32'(waddr), 32'hFFFF_FFFF);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("waddr", 32'(waddr), 32'(e.addr));
            check("wdata", wdata, e.data);
         end
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
         if (exp_done == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_done--;
            check("writes_pending_at_done", 32'(exp_q.size()), 32'd0);
         end
      end
   end

   // Drive byte_q into the loader; gap_pct sets the chance of a byte_valid=0
   // cycle, noise toggles start/word_count to confirm they are ignored
   task automatic feed(input int gap_pct, input bit noise);
      int i     = 0;
      int spins = 0;
      int gaps  = 0;
      bit gap;
      bit acc;
      gb_q.delete();
      while (i < byte_q.size() && spins < 2000) begin
         gap        = ($urandom_range(0, 99) < gap_pct);
         byte_valid = !gap;
         byte_data  = gap ? 8'($urandom) : byte_q[i];
         if (noise) begin
            start      = 1'($urandom_range(0, 1));
            word_count = 7'($urandom_range(0, 127));
         end
         @(negedge clk);
         acc = byte_valid && byte_ready;
         if (byte_ready && !byte_valid) gaps++;
         @(posedge clk);
         #1;
         if (acc) begin
            if ((i % 4) == 3) gb_q.push_back(gaps);
            i++;
         end
         spins++;
      end
      byte_valid = 1'b0;
      start      = 1'b0;
      if (spins >= 2000) check("feed_timeout", 32'(i), 32'(byte_q.size()));
   endtask

   // Reference load: word k lands at byte address 4k, sent low byte first;
   // the k-th write appears 4 + 5k cycles after start plus stall cycles
   task automatic run_load(input int wc, input int gap_pct, input bit noise);
      int n;
      int t0;
      int d0;
      int spins = 0;
      int exp_done_cyc;
      n = (wc > 64) ? 64 : wc;
      byte_q.delete();
      we_cyc_q.delete();
      for (int k = 0; k < n; k++) begin
         exp_q.push_back('{addr: 8'(k * 4), data: words[k]});
         for (int j = 0; j < 4; j++) byte_q.push_back(8'((words[k] >> (8 * j)) & 32'hFF));
      end
      exp_done++;
      d0         = done_cnt;
      word_count = 7'(wc);
      start      = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      t0    = cyc;
      feed(gap_pct, noise);
      while (done_cnt == d0 && spins < 100) begin
         @(negedge clk);
         spins++;
      end
      if (done_cnt == d0) check("done_timeout", 32'd0, 32'd1);
      check("we_count", 32'(we_cyc_q.size()), 32'(n));
      for (int k = 0; k < n && k < we_cyc_q.size() && k < gb_q.size(); k++)
         check("we_cycle", 32'(we_cyc_q[k] - t0), 32'(4 + 5 * k + gb_q[k]));
      exp_done_cyc = (n == 0) ? t0 : t0 + 5 + 5 * (n - 1) + gb_q[n - 1];
      check("done_cycle", 32'(done_cyc - t0), 32'(exp_done_cyc - t0));
      @(negedge clk);
      check("cpu_hold_after", 32'(cpu_hold), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic rand_words(input int n);
      words.delete();
      for (int k = 0; k < n; k++) words.push_back($urandom);
   endtask

   task automatic check_reset_outputs();
      check("rst_byte_ready", 32'(byte_ready), 32'd0);
      check("rst_we", 32'(we), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
      check("rst_waddr", 32'(waddr), 32'd0);
      check("rst_wdata", wdata, 32'd0);
   endtask

   initial begin
      reset      = 1'b1;
      start      = 1'b0;
      word_count = 7'd0;
      byte_valid = 1'b0;
      byte_data  = 8'd0;
      #1;
      check_reset_outputs();
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Basic two-word load, then the same words with stall cycles
      words.delete();
      words.push_back(32'h00c0_8093);
      words.push_back(32'h0001_0463);
      run_load(2, 0, 1'b0);
      run_load(2, 35, 1'b0);

      // Zero-length and over-length requests
      run_load(0, 0, 1'b0);
      rand_words(64);
      run_load(100, 10, 1'b0);

      // start and word_count wiggled during collection
      rand_words(3);
      run_load(3, 20, 1'b1);

      // Back-to-back bytes give one write every five cycles
      rand_words(4);
      run_load(4, 0, 1'b0);

      // Reset after two bytes of the second word
      rand_words(3);
      we_cyc_q.delete();
      byte_q.delete();
      exp_q.push_back('{addr: 8'h00, data: words[0]});
      for (int j = 0; j < 6; j++) byte_q.push_back(8'((words[j / 4] >> (8 * (j % 4))) & 32'hFF));
      word_count = 7'd3;
      start      = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      feed(0, 1'b0);
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check_reset_outputs();
      check("writes_before_reset", 32'(we_cyc_q.size()), 32'd1);
      byte_valid = 1'b1;
      byte_data  = 8'hA5;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      byte_valid = 1'b0;
      check("writes_after_reset", 32'(we_cyc_q.size()), 32'd1);
      check("idle_after_reset", 32'(cpu_hold), 32'd0);
      rand_words(1);
      run_load(1, 0, 1'b0);

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      check("done_tokens_left", 32'(exp_done), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: DEPTH, 64, instruction memory depth in 32-bit words; word index fits in waddr[7:2].
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin a load; sampled only in IDLE.
REQ-005 word_count  input  7  number of words to load; latched on accepted start.
REQ-006 byte_valid  input  1  byte_data is valid this cycle.
REQ-007 byte_data  input  8  incoming program byte, little-endian within each word.
REQ-008 byte_ready  output  1  loader accepts a byte this cycle.
REQ-009 we  output  1  instruction memory write enable, one-cycle pulse per word.
REQ-010 waddr  output  8  byte address of the written word, always 4-aligned (waddr[1:0]=0).
REQ-011 wdata  output  32  assembled instruction word.
REQ-012 cpu_hold  output  1  high while a load is in progress; the CPU stalls fetch and PC.
REQ-013 done  output  1  one-cycle pulse when a load completes.

Function
REQ-014 State machine SHALL have the states IDLE, COLLECT, WRITE and DONE; the state is registered.
REQ-015 IDLE: on start=1, latch count = word_count clamped to DEPTH, clear word_idx and byte_idx, then go to COLLECT; if the latched count is 0, go to DONE directly.
REQ-016 start SHALL be ignored in every state other than IDLE.
REQ-017 byte_ready SHALL be 1 only in COLLECT; a byte is accepted when byte_valid and byte_ready are both 1 in the same cycle.
REQ-018 Accepted byte k (k=0..3) SHALL be stored in word bits [8k+7:8k]; byte_idx increments modulo 4.
REQ-019 When the 4th byte is accepted, the next state SHALL be WRITE; byte_ready SHALL be 0 in WRITE.
REQ-020 WRITE SHALL last exactly 1 cycle, with we=1, waddr={word_idx[5:0],2'b00} and wdata = the assembled word.
REQ-021 After WRITE: if word_idx == count-1, go to DONE; otherwise increment word_idx and return to COLLECT.
REQ-022 DONE SHALL last 1 cycle with done=1, then return to IDLE.
REQ-023 cpu_hold SHALL be 1 in COLLECT, WRITE and DONE, and 0 in IDLE.
REQ-024 we=0 and done=0 in every state other than those named above; waddr and wdata hold their last value when we=0.
REQ-025 byte_valid=0 gaps SHALL stall collection indefinitely without losing partial-word bytes.
REQ-026 The maximum load of 64 words SHALL write waddr 0x00..0xFC with no wrap; word_count values above 64 SHALL clamp to 64.
REQ-027 Throughput: 1 word per 5 cycles with continuous byte_valid (4 accept cycles + 1 write cycle).

Reset
REQ-028 Asserting reset SHALL immediately force state=IDLE, byte_ready=0, we=0, done=0, cpu_hold=0, waddr=0, wdata=0, word_idx=0, byte_idx=0 and count=0.
REQ-029 Reset during a load SHALL discard the partial word; words already written stay in memory, and no write or done SHALL occur after reset.
REQ-030 After reset deasserts, the loader SHALL wait in IDLE for a new start.

Verification
REQ-031 Basic load: start, word_count=2, bytes 93,80,c0,00,63,04,01,00 -> we at waddr 0x00 with wdata 0x00c08093, then we at waddr 0x04 with wdata 0x00010463, done pulse, cpu_hold low afterwards.
REQ-032 Backpressure gaps: insert random byte_valid=0 cycles during scenario REQ-031 -> identical writes; the cycle of each we pulse shifts by exactly the number of gap cycles.
REQ-033 Edge counts: word_count=0 -> done one cycle after start and no we; word_count=100 -> exactly 64 writes, last waddr 0xFC.
REQ-034 Reset mid-load: reset after 2 bytes of word 1 -> all outputs reach their reset values asynchronously and no further we; a new load then starts at waddr 0x00.
REQ-035 Ignored start: pulse start during COLLECT -> no effect on count, word_idx or addresses; exactly the originally requested number of writes occurs.
REQ-036 Throughput: continuous byte_valid with word_count=4 -> 4 we pulses spaced 5 cycles apart, and done in the cycle after the last WRITE.
